// File: rtl/and_ctrl_rr_sched.sv
// ---------------------------------------------------------------------------
// and_ctrl_rr_sched
//   Round-robin scheduler that shares one combinational AND/invert unit among
//   NUM_REQ requesters. Each transaction accepts one request, drives the
//   shared unit for one settle cycle, captures its 1-bit result and returns
//   it over a valid/ready response channel.
//
// Ports
//   clk, rst_n              clock (posedge) and asynchronous active-low reset
//   req_valid / req_ready   per-requester request handshake (ready is a
//                           one-hot, single-cycle accept pulse)
//   req_a..req_d            packed operands, requester i at [i*OP_W +: OP_W]
//   req_ctrl                per-requester invert select
//   pwr_ok                  shared unit powered; low blocks new grants only
//   unit_a..unit_d          registered operands to the shared unit
//   unit_ctrl               registered invert control to the shared unit
//   unit_out                combinational result from the shared unit
//   rsp_valid / rsp_ready   response handshake
//   rsp_id, rsp_data        owning requester and captured unit result
//   busy                    high whenever a transaction is in flight
//   txn_cnt                 completed transactions, saturating at all-ones
// ---------------------------------------------------------------------------
module and_ctrl_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OP_W-1:0]    req_a,
  input  logic [NUM_REQ*OP_W-1:0]    req_b,
  input  logic [NUM_REQ*OP_W-1:0]    req_c,
  input  logic [NUM_REQ*OP_W-1:0]    req_d,
  input  logic [NUM_REQ-1:0]         req_ctrl,
  input  logic                       pwr_ok,
  output logic [OP_W-1:0]            unit_a,
  output logic [OP_W-1:0]            unit_b,
  output logic [OP_W-1:0]            unit_c,
  output logic [OP_W-1:0]            unit_d,
  output logic                       unit_ctrl,
  input  logic                       unit_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_data,
  output logic                       busy,
  output logic [CNT_W-1:0]           txn_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lat_id;
  logic [ID_W-1:0] grant_id;
  logic            grant_found;
  logic            accept;
  logic            rsp_fire;

  // Rotating priority search: walk the requesters starting at rr_ptr and
  // wrapping modulo NUM_REQ, so the first valid one found is the grant. The
  // explicit wrap keeps this correct for non-power-of-two NUM_REQ.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // State register for the IDLE -> ISSUE -> RESP loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. The accept pulse is purely
  // combinational so a requester sees req_ready in the same cycle it is
  // chosen; it is also held off while reset is asserted so nothing is
  // accepted during reset.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pwr_ok && grant_found && rst_n) begin
          accept              = 1'b1;
          req_ready[grant_id] = 1'b1;
          next_state          = ISSUE;
        end
      end
      ISSUE: begin
        next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire   = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. Operands go straight into the unit-facing registers at accept
  // so they are stable for the whole ISSUE cycle, and are cleared again as
  // ISSUE ends, which is also when the settled unit result is captured.
  // rsp_id/rsp_data only change on ISSUE exit, so they stay put through any
  // amount of response backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_a    <= '0;
      unit_b    <= '0;
      unit_c    <= '0;
      unit_d    <= '0;
      unit_ctrl <= 1'b0;
      lat_id    <= '0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
    end else if (accept) begin
      unit_a    <= req_a[grant_id*OP_W +: OP_W];
      unit_b    <= req_b[grant_id*OP_W +: OP_W];
      unit_c    <= req_c[grant_id*OP_W +: OP_W];
      unit_d    <= req_d[grant_id*OP_W +: OP_W];
      unit_ctrl <= req_ctrl[grant_id];
      lat_id    <= grant_id;
    end else if (state == ISSUE) begin
      unit_a    <= '0;
      unit_b    <= '0;
      unit_c    <= '0;
      unit_d    <= '0;
      unit_ctrl <= 1'b0;
      rsp_data  <= unit_out;
      rsp_id    <= lat_id;
    end
  end

  // Fairness pointer and completion counter advance only on a completed
  // response handshake, so a transaction dropped by reset never counts and
  // never moves the priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      txn_cnt <= '0;
    end else if (rsp_fire) begin
      rr_ptr <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
      if (txn_cnt != '1) begin
        txn_cnt <= txn_cnt + 1'b1;
      end
    end
  end

endmodule
